imm_encoder: RTL and testbench

Pipelined instruction encoder: the inverse of the immediate-extension path in the single-cycle core's decode stage. It accepts decoded instruction fields plus a full 32-bit immediate and an immediate-format code. It packs them into a 32-bit RV32I instruction word, range-checks the immediate, and streams the word out with an auto-incrementing instruction-memory byte address. It feeds the instruction-memory loader and the self-checking test program generator.

---
 rtl/riscv_imm_pkg.sv | 34 +++
 rtl/imm_field_pack.sv | 57 +++++
 rtl/imm_encoder.sv | 147 ++++++++++++++
 tb/tb_imm_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
// Immediate-format codes, legal immediate ranges and the field bundle shared by
// the instruction encoder and the decode-stage immediate extender.
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_J = 3'b010,
        IMM_R = 3'b011,
        IMM_B = 3'b101,
        IMM_U = 3'b110
    } immsrc_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  immsrc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_fields_t;

endpackage

// File: rtl/imm_field_pack.sv
// Scatters a 32-bit immediate into its instruction bit positions for the given
// format and flags out-of-range/misaligned values; purely combinational.
module imm_field_pack
    import riscv_imm_pkg::*;
(
    input  logic [2:0]  immsrc,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        fmt_ok,
    output logic        err
);

    logic signed [31:0] simm;

    assign simm = imm;

    always_comb begin
        imm_bits = '0;
        fmt_ok   = 1'b1;
        err      = 1'b0;
        case (immsrc)
            IMM_I: begin
                imm_bits[31:20] = imm[11:0];
                err = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            IMM_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                err = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            IMM_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                err = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
            end
            IMM_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                err = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
            end
            IMM_U: begin
                imm_bits[31:12] = imm[31:12];
                err = (imm[11:0] != 12'd0);
            end
            IMM_R: ;
            default: begin
                fmt_ok = 1'b0;
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs decoded fields + immediate into an RV32I word, streamed with a byte address.
// Two register stages (accept edge, then word visible after the next edge); stalls on out_ready low.
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_immsrc,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    enc_fields_t       s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_inst_q, s2_inst_d;
    logic              s2_err_q, s2_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              s2_free, in_fire, out_fire;
    logic [31:0]       imm_bits, word;
    logic              fmt_ok, pack_err;

    imm_field_pack u_pack (
        .immsrc   (s1_q.immsrc),
        .imm      (s1_q.imm),
        .imm_bits (imm_bits),
        .fmt_ok   (fmt_ok),
        .err      (pack_err)
    );

    // S1 may refill in the same cycle it hands its beat to S2.
    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        word      = imm_bits;
        word[6:0] = s1_q.opcode;
        case (s1_q.immsrc)
            IMM_I: begin
                word[11:7]  = s1_q.rd;
                word[14:12] = s1_q.funct3;
                word[19:15] = s1_q.rs1;
            end
            IMM_S, IMM_B: begin
                word[14:12] = s1_q.funct3;
                word[19:15] = s1_q.rs1;
                word[24:20] = s1_q.rs2;
            end
            IMM_J, IMM_U: begin
                word[11:7] = s1_q.rd;
            end
            IMM_R: begin
                word[11:7]  = s1_q.rd;
                word[14:12] = s1_q.funct3;
                word[19:15] = s1_q.rs1;
                word[24:20] = s1_q.rs2;
                word[31:25] = s1_q.funct7;
            end
            default: ;
        endcase
        if (!fmt_ok) begin
            word = NOP_INST;
        end
    end

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = word;
                s2_err_d  = pack_err;
            end
        end

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d = '{immsrc: in_immsrc, opcode: in_opcode, rd: in_rd,
                     funct3: in_funct3, rs1: in_rs1, rs2: in_rs2,
                     funct7: in_funct7, imm: in_imm};
        end else if (s1_valid_q && s2_free) begin
            s1_valid_d = 1'b0;
        end

        if (out_fire) begin
            addr_d = addr_q + ADDR_W'(4);
            if (s2_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_cnt_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign out_addr  = addr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised and directed bench for imm_encoder against a field-arithmetic model.
module tb_imm_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err;
    logic [2:0]  in_immsrc = '0, in_funct3 = '0;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0, out_inst, out_addr;
    logic [7:0]  err_count;

    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1, w_out_err;
    logic [31:0] w_out_inst;
    logic [3:0]  w_out_addr;
    logic [7:0]  w_err_count;

    always #5 clk = ~clk;

    imm_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    imm_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_wrap (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_immsrc(in_immsrc), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inst(w_out_inst),
        .out_addr(w_out_addr), .out_err(w_out_err), .err_count(w_err_count)
    );

    typedef struct {
        logic [2:0]  src;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } beat_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;

    exp_t        sb[$];
    logic [31:0] m_addr;
    int          m_cnt;
    logic [31:0] got_inst[$];
    logic [31:0] got_addr[$];
    logic        got_err[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst, prev_addr;
    logic        prev_err;
    bit          saw_full;
    beat_t       idle_b;

    int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    -1048577, -1048576, 1048574, 1048575, 1048576};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] v, input int sh);
        return v << sh;
    endfunction

    // Reference: field placement by plain shifts/masks, range rules by signed integer compare.
    function automatic exp_t ref_model(input beat_t b);
        exp_t        e;
        int          v;
        logic [31:0] x;
        logic [31:0] base_r;
        x = b.imm;
        v = $signed(b.imm);
        base_r = at(32'(b.rs1), 15) | at(32'(b.f3), 12) | 32'(b.op);
        e.err = 1'b0;
        case (b.src)
            3'b000: begin
                e.inst = at(x & 32'hFFF, 20) | base_r | at(32'(b.rd), 7);
                e.err  = (v < -2048) || (v > 2047);
            end
            3'b001: begin
                e.inst = at((x >> 5) & 32'h7F, 25) | at(32'(b.rs2), 20) | base_r | at(x & 32'h1F, 7);
                e.err  = (v < -2048) || (v > 2047);
            end
            3'b101: begin
                e.inst = at((x >> 12) & 32'h1, 31) | at((x >> 5) & 32'h3F, 25) | at(32'(b.rs2), 20)
                       | base_r | at((x >> 1) & 32'hF, 8) | at((x >> 11) & 32'h1, 7);
                e.err  = (v < -4096) || (v > 4094) || x[0];
            end
            3'b010: begin
                e.inst = at((x >> 20) & 32'h1, 31) | at((x >> 1) & 32'h3FF, 21) | at((x >> 11) & 32'h1, 20)
                       | at((x >> 12) & 32'hFF, 12) | at(32'(b.rd), 7) | 32'(b.op);
                e.err  = (v < -1048576) || (v > 1048574) || x[0];
            end
            3'b110: begin
                e.inst = (x & 32'hFFFF_F000) | at(32'(b.rd), 7) | 32'(b.op);
                e.err  = (x % 4096) != 0;
            end
            3'b011: begin
                e.inst = at(32'(b.f7), 25) | at(32'(b.rs2), 20) | base_r | at(32'(b.rd), 7);
            end
            default: begin
                e.inst = 32'h0000_0013;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic beat_t mk(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [6:0] f7, input logic [31:0] imm);
        beat_t b;
        b.src = src; b.op = op; b.rd = rd; b.f3 = f3;
        b.rs1 = rs1; b.rs2 = rs2; b.f7 = f7; b.imm = imm;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        case ($urandom_range(0, 13))
            0, 1:    b.src = 3'b000;
            2, 3:    b.src = 3'b001;
            4, 5:    b.src = 3'b101;
            6, 7:    b.src = 3'b010;
            8, 9:    b.src = 3'b110;
            10, 11:  b.src = 3'b011;
            12:      b.src = 3'b100;
            default: b.src = 3'b111;
        endcase
        b.op  = 7'($urandom);
        b.rd  = 5'($urandom);
        b.f3  = 3'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        b.f7  = 7'($urandom);
        case ($urandom_range(0, 5))
            0:       b.imm = 32'($urandom);
            1:       b.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            2:       b.imm = 32'(bnd[$urandom_range(0, 13)]);
            3:       b.imm = 32'($urandom) & 32'hFFFF_F000;
            4:       b.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
            default: b.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        endcase
        return b;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, then advance to next negedge.
    task automatic cycle(input bit v, input beat_t b, input bit ordy, input bit fl,
                         output bit in_f, output bit out_f);
        exp_t e;
        in_valid  = v;
        in_immsrc = b.src; in_opcode = b.op; in_rd = b.rd; in_funct3 = b.f3;
        in_rs1    = b.rs1; in_rs2 = b.rs2; in_funct7 = b.f7; in_imm = b.imm;
        out_ready = ordy;
        flush     = fl;
        #1;
        in_f  = v && in_ready;
        out_f = out_valid && ordy;
        if (prev_stall) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_inst", out_inst, prev_inst);
            check_eq("hold_addr", out_addr, prev_addr);
            check_eq("hold_err", 32'(out_err), 32'(prev_err));
        end
        prev_stall = out_valid && !ordy && !fl;
        prev_inst  = out_inst;
        prev_addr  = out_addr;
        prev_err   = out_err;
        if (v && !in_ready) saw_full = 1'b1;
        if (fl) begin
            sb.delete();
            m_addr = BASE;
            m_cnt  = 0;
            in_f   = 1'b0;
            out_f  = 1'b0;
        end else begin
            if (out_f) begin
                check_eq("out_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("out_inst", out_inst, e.inst);
                    check_eq("out_err", 32'(out_err), 32'(e.err));
                    check_eq("out_addr", out_addr, m_addr);
                    check_eq("err_count", 32'(err_count), 32'(m_cnt));
                    m_addr = m_addr + 32'd4;
                    if (e.err && m_cnt < 255) m_cnt++;
                end
                got_inst.push_back(out_inst);
                got_addr.push_back(out_addr);
                got_err.push_back(out_err);
            end
            if (in_f) sb.push_back(ref_model(b));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input beat_t b);
        bit i, o;
        int n;
        i = 1'b0;
        n = 0;
        while (!i && n < 50) begin
            cycle(1'b1, b, 1'b1, 1'b0, i, o);
            n++;
        end
        check_eq("send_accepted", 32'(i), 32'd1);
    endtask

    task automatic drain();
        bit i, o;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle(1'b0, idle_b, 1'b1, 1'b0, i, o);
            n++;
        end
        check_eq("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_flush();
        bit i, o;
        cycle(1'b1, mk(3'b000, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1), 1'b1, 1'b1, i, o);
        got_inst.delete();
        got_addr.delete();
        got_err.delete();
    endtask

    initial begin
        bit    i, o;
        int    lat, sent, seen;
        beat_t bp[5];
        beat_t rb, bw;

        idle_b = mk(3'b000, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        m_addr = BASE;
        m_cnt  = 0;

        // reset held with a valid beat offered: it must be ignored
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_inst", out_inst, 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_out_addr", out_addr, BASE);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // I-type with latency measurement
        send(mk(3'b000, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5));
        lat = 0;
        o = 1'b0;
        while (!o && lat < 10) begin
            cycle(1'b0, idle_b, 1'b1, 1'b0, i, o);
            lat++;
        end
        check_eq("i_latency", 32'(lat), 32'd2);
        check_eq("i_inst", got_inst[0], 32'h0050_0093);
        check_eq("i_addr", got_addr[0], BASE);

        // S then B back to back
        do_flush();
        send(mk(3'b001, 7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8));
        send(mk(3'b101, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC));
        drain();
        check_eq("s_inst", got_inst[0], 32'h0020_A423);
        check_eq("s_addr", got_addr[0], BASE);
        check_eq("b_inst", got_inst[1], 32'hFE00_0EE3);
        check_eq("b_addr", got_addr[1], BASE + 32'd4);

        // J and U
        do_flush();
        send(mk(3'b010, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048));
        send(mk(3'b110, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000));
        drain();
        check_eq("jal_inst", got_inst[0], 32'h0010_00EF);
        check_eq("lui_inst", got_inst[1], 32'h1234_52B7);

        // error cases, cumulative err_count
        do_flush();
        send(mk(3'b000, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048));
        drain();
        check_eq("addi2048_err", 32'(got_err[0]), 32'd1);
        check_eq("addi2048_cnt", 32'(err_count), 32'd1);
        send(mk(3'b101, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd6));
        drain();
        check_eq("b6_err", 32'(got_err[1]), 32'd0);
        check_eq("b6_cnt", 32'(err_count), 32'd1);
        send(mk(3'b101, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3));
        drain();
        check_eq("b3_err", 32'(got_err[2]), 32'd1);
        check_eq("b3_cnt", 32'(err_count), 32'd2);
        send(mk(3'b111, 7'b0110011, 5'd7, 3'd1, 5'd2, 5'd3, 7'd1, 32'd0));
        drain();
        check_eq("undef_inst", got_inst[3], 32'h0000_0013);
        check_eq("undef_cnt", 32'(err_count), 32'd3);

        // backpressure: out_ready low for cycles 3..5 of a 5-beat stream
        do_flush();
        for (int k = 0; k < 5; k++)
            bp[k] = mk(3'b000, 7'b0010011, 5'(k + 1), 3'd0, 5'(k), 5'd0, 7'd0, 32'(k * 100 - 150));
        saw_full = 1'b0;
        sent = 0;
        for (int k = 0; k < 40 && (sent < 5 || sb.size() != 0); k++) begin
            rb = (sent < 5) ? bp[sent] : idle_b;
            cycle(sent < 5, rb, !(k >= 3 && k <= 5), 1'b0, i, o);
            if (i) sent++;
        end
        check_eq("bp_in_ready_drop", 32'(saw_full), 32'd1);
        check_eq("bp_count", 32'(got_inst.size()), 32'd5);
        for (int k = 0; k < 5 && k < got_inst.size(); k++) begin
            check_eq("bp_order", got_inst[k], ref_model(bp[k]).inst);
            check_eq("bp_addr", got_addr[k], BASE + 32'(4 * k));
        end

        // flush with two beats in flight
        do_flush();
        send(mk(3'b000, 7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4000));
        drain();
        check_eq("pre_flush_cnt", 32'(err_count), 32'd1);
        send(mk(3'b000, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1));
        send(mk(3'b000, 7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2));
        do_flush();
        #1;
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_err_count", 32'(err_count), 32'd0);
        check_eq("flush_addr", out_addr, BASE);
        @(negedge clk);
        send(mk(3'b000, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3));
        drain();
        check_eq("post_flush_count", 32'(got_inst.size()), 32'd1);
        check_eq("post_flush_addr", got_addr[0], BASE);

        // err_count saturation
        do_flush();
        for (int k = 0; k < 260; k++)
            cycle(1'b1, mk(3'b110, 7'b0110111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1), 1'b1, 1'b0, i, o);
        drain();
        check_eq("sat_err_count", 32'(err_count), 32'd255);

        // randomised traffic with random stalls and occasional flush
        do_flush();
        rb = rand_beat();
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 3) != 0, rb, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 59) == 0, i, o);
            if (i) rb = rand_beat();
        end
        drain();

        // narrow address counter wraps 0xC -> 0x0
        in_valid = 1'b0;
        bw = mk(3'b011, 7'b0110011, 5'd9, 3'd4, 5'd10, 5'd11, 7'h20, 32'd0);
        in_immsrc = bw.src; in_opcode = bw.op; in_rd = bw.rd; in_funct3 = bw.f3;
        in_rs1 = bw.rs1; in_rs2 = bw.rs2; in_funct7 = bw.f7; in_imm = bw.imm;
        w_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 8 && seen < 2; n++) begin
            #1;
            if (w_out_valid) begin
                check_eq("wrap_inst", w_out_inst, ref_model(bw).inst);
                check_eq("wrap_addr", 32'(w_out_addr), (seen == 0) ? 32'hC : 32'h0);
                seen++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("wrap_seen", 32'(seen), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

endmodule
